// File: rtl/c4_move_sequencer.sv
// Connect 4 turn scheduler: owns the board write port, places tokens, scans for wins.
// Optional macro C4_ALTERNATE_START_EN alternates the opening player between games.
module c4_move_sequencer #(
    parameter int COLS    = 7,
    parameter int ROWS    = 6,
    parameter int WIN_LEN = 4
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       start,
    input  logic       req_valid,
    input  logic [2:0] req_col,
    output logic       req_ready,
    output logic [5:0] rd_addr,
    input  logic [1:0] rd_data,
    output logic       wr_en,
    output logic [5:0] wr_addr,
    output logic [1:0] wr_data,
    output logic [1:0] cur_player,
    output logic       move_done,
    output logic       move_reject,
    output logic       win,
    output logic [1:0] winner,
    output logic       draw
);
    localparam int CELLS = ROWS * COLS;
    localparam int SW    = $clog2(WIN_LEN);
    localparam int NW    = $clog2(WIN_LEN + 1);
    localparam int HW    = $clog2(ROWS + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, WAIT_REQ, WRITE, SCAN, OVER} state_t;

    state_t          state;
    logic [2:0]      row_q;
    logic [2:0]      col_q;
    logic [2:0]      side_q;
    logic [SW-1:0]   step_q;
    logic [NW-1:0]   cnt_q;
    logic [5:0]      moves_q;
    logic [HW-1:0]   col_count [COLS];
`ifdef C4_ALTERNATE_START_EN
    logic [1:0]      next_first;
`endif

    logic [2:0]      req_sel;
    logic            req_bad;
    logic [2:0]      land_row;
    logic [5:0]      land_addr;
    logic            hit;
    logic            win_now;
    logic            stay_side;
    logic [3:0]      nside;
    logic [NW-1:0]   cnt_inc;

    // Side index: bits [2:1] pick H, V, diag /, diag \; bit 0 selects the negative walk.
    function automatic void step_rc(input logic [2:0] side, input int step, input int row,
                                    input int col, output int r, output int c);
        int dr;
        int dc;
        case (side[2:1])
            2'd0:    begin dr = 0;  dc = 1; end
            2'd1:    begin dr = 1;  dc = 0; end
            2'd2:    begin dr = -1; dc = 1; end
            default: begin dr = 1;  dc = 1; end
        endcase
        if (side[0]) begin
            dr = -dr;
            dc = -dc;
        end
        r = row + dr * step;
        c = col + dc * step;
    endfunction

    function automatic logic cell_ok(input logic [2:0] side, input int step, input int row,
                                     input int col);
        int r;
        int c;
        step_rc(side, step, row, col, r, c);
        return (r >= 0) && (r < ROWS) && (c >= 0) && (c < COLS);
    endfunction

    function automatic logic [5:0] cell_addr(input logic [2:0] side, input int step,
                                             input int row, input int col);
        int r;
        int c;
        step_rc(side, step, row, col, r, c);
        return 6'(r * COLS + c);
    endfunction

    // Sides whose first cell is off the board are skipped without spending a cycle; 8 means none left.
    function automatic logic [3:0] first_side(input int from, input int row, input int col);
        logic [3:0] res;
        res = 4'd8;
        for (int s = 7; s >= 0; s--) begin
            if (s >= from && cell_ok(3'(s), 1, row, col)) res = 4'(s);
        end
        return res;
    endfunction

    always_comb begin
        req_sel   = (int'(req_col) < COLS) ? req_col : 3'd0;
        req_bad   = (int'(req_col) >= COLS) || (int'(col_count[req_sel]) == ROWS);
        land_row  = 3'(ROWS - 1 - int'(col_count[req_sel]));
        land_addr = 6'(int'(land_row) * COLS + int'(req_col));
        hit       = (rd_data == cur_player);
        cnt_inc   = cnt_q + NW'(hit);
        win_now   = hit && (int'(cnt_q) + 1 >= WIN_LEN);
        stay_side = hit && (int'(step_q) < WIN_LEN - 1) &&
                    cell_ok(side_q, int'(step_q) + 1, int'(row_q), int'(col_q));
        nside     = first_side((state == WRITE) ? 0 : int'(side_q) + 1, int'(row_q), int'(col_q));
    end

    assign rd_addr = cell_addr(side_q, int'(step_q), int'(row_q), int'(col_q));

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            cur_player  <= 2'b01;
            move_done   <= 1'b0;
            move_reject <= 1'b0;
            win         <= 1'b0;
            winner      <= '0;
            draw        <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            side_q      <= '0;
            step_q      <= '0;
            cnt_q       <= '0;
            moves_q     <= '0;
            for (int i = 0; i < COLS; i++) col_count[i] <= '0;
`ifdef C4_ALTERNATE_START_EN
            next_first  <= 2'b01;
`endif
        end else begin
            move_done   <= 1'b0;
            move_reject <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state   <= CLEAR;
                        wr_en   <= 1'b1;
                        wr_addr <= '0;
                        wr_data <= '0;
`ifdef C4_ALTERNATE_START_EN
                        cur_player <= next_first;
                        next_first <= {next_first[0], next_first[1]};
`else
                        cur_player <= 2'b01;
`endif
                    end
                end
                CLEAR: begin
                    if (wr_addr == 6'(CELLS - 1)) begin
                        state     <= WAIT_REQ;
                        wr_en     <= 1'b0;
                        req_ready <= 1'b1;
                        moves_q   <= '0;
                        win       <= 1'b0;
                        winner    <= '0;
                        draw      <= 1'b0;
                        for (int i = 0; i < COLS; i++) col_count[i] <= '0;
                    end else begin
                        wr_addr <= wr_addr + 6'd1;
                    end
                end
                WAIT_REQ: begin
                    if (req_valid) begin
                        if (req_bad) begin
                            move_reject <= 1'b1;
                        end else begin
                            state     <= WRITE;
                            req_ready <= 1'b0;
                            row_q     <= land_row;
                            col_q     <= req_col;
                            wr_en     <= 1'b1;
                            wr_addr   <= land_addr;
                            wr_data   <= cur_player;
                        end
                    end
                end
                WRITE: begin
                    state             <= SCAN;
                    wr_en             <= 1'b0;
                    col_count[col_q]  <= col_count[col_q] + HW'(1);
                    moves_q           <= moves_q + 6'd1;
                    side_q            <= nside[2:0];
                    step_q            <= SW'(1);
                    cnt_q             <= NW'(1);
                end
                SCAN: begin
                    if (win_now || (!stay_side && nside[3])) begin
                        move_done <= 1'b1;
                        if (win_now) begin
                            win    <= 1'b1;
                            winner <= cur_player;
                            state  <= OVER;
                        end else if (moves_q == 6'(CELLS)) begin
                            draw  <= 1'b1;
                            state <= OVER;
                        end else begin
                            cur_player <= ~cur_player;
                            req_ready  <= 1'b1;
                            state      <= WAIT_REQ;
                        end
                    end else if (stay_side) begin
                        step_q <= step_q + SW'(1);
                        cnt_q  <= cnt_inc;
                    end else begin
                        // The run count carries from the + side into the - side of the same line.
                        side_q <= nside[2:0];
                        step_q <= SW'(1);
                        cnt_q  <= (nside[2:1] == side_q[2:1]) ? cnt_inc : NW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
